// File: rtl/svc_sram_arbiter_pkg.sv
// Shared types for the SRAM request arbiter.
//   state_t : arbiter FSM states
//   dir_t   : transfer direction (read / write)
//   grant_state() maps a direction onto its GRANT state.
package svc_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    GRANT_RD,
    GRANT_WR
  } state_t;

  typedef enum logic {
    DIR_RD,
    DIR_WR
  } dir_t;

  function automatic state_t grant_state(input dir_t dir);
    return (dir == DIR_WR) ? GRANT_WR : GRANT_RD;
  endfunction

endpackage

// File: rtl/svc_sram_arbiter_if.sv
// Bus bundle between the framebuffer clients, the arbiter and the SRAM
// controller request port.
//   s_rd_*  : display read requester (request + response passthrough)
//   s_wr_*  : graphics write requester
//   m_*     : SRAM controller request port and read response
//   wr_starved : status, pending write has waited the maximum time
// Modports:
//   slave  : the arbiter's view (requests and controller ready/response in)
//   master : the surrounding system's view (clients and controller)
interface svc_sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  s_rd_valid;
  logic                  s_rd_ready;
  logic [ADDR_WIDTH-1:0] s_rd_addr;
  logic                  s_rd_resp_valid;
  logic [DATA_WIDTH-1:0] s_rd_resp_data;

  logic                  s_wr_valid;
  logic                  s_wr_ready;
  logic [ADDR_WIDTH-1:0] s_wr_addr;
  logic [DATA_WIDTH-1:0] s_wr_data;

  logic                  m_valid;
  logic                  m_ready;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_rd_resp_valid;
  logic [DATA_WIDTH-1:0] m_rd_resp_data;

  logic                  wr_starved;

  modport slave (
    input  s_rd_valid, s_rd_addr,
    input  s_wr_valid, s_wr_addr, s_wr_data,
    input  m_ready, m_rd_resp_valid, m_rd_resp_data,
    output s_rd_ready, s_rd_resp_valid, s_rd_resp_data,
    output s_wr_ready,
    output m_valid, m_we, m_addr, m_data,
    output wr_starved
  );

  modport master (
    output s_rd_valid, s_rd_addr,
    output s_wr_valid, s_wr_addr, s_wr_data,
    output m_ready, m_rd_resp_valid, m_rd_resp_data,
    input  s_rd_ready, s_rd_resp_valid, s_rd_resp_data,
    input  s_wr_ready,
    input  m_valid, m_we, m_addr, m_data,
    input  wr_starved
  );

endinterface

// File: rtl/svc_sram_arbiter.sv
// Read-priority arbiter sharing one SRAM controller request port between a
// display read requester and a graphics write requester.
//   clk : memory clock
//   rst : synchronous, active-high reset
//   bus : svc_sram_arbiter_if.slave (s_rd_*, s_wr_*, m_*, wr_starved)
// Grants are burst-sticky up to BURST_MAX beats; a direction change inserts
// TURNAROUND idle cycles; a write waiting WR_MAX_WAIT cycles is forced next.
// Read responses pass straight through; no outstanding reads are tracked.
module svc_sram_arbiter
  import svc_sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BURST_MAX   = 16,
  parameter int unsigned WR_MAX_WAIT = 8,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic                clk,
  input  logic                rst,
  svc_sram_arbiter_if.slave   bus
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned WW = $clog2(WR_MAX_WAIT + 1);
  localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(WR_MAX_WAIT);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_t        state_q,       state_d;
  dir_t          last_dir_q,    last_dir_d;
  dir_t          pending_dir_q, pending_dir_d;
  logic [BW-1:0] beat_cnt_q,    beat_cnt_d;
  logic [TW-1:0] turn_cnt_q,    turn_cnt_d;
  logic [WW-1:0] wr_wait_cnt_q, wr_wait_cnt_d;

  logic                  m_valid_c;
  logic                  m_we_c;
  logic [ADDR_WIDTH-1:0] m_addr_c;
  logic [DATA_WIDTH-1:0] m_data_c;
  logic                  rd_ready_c;
  logic                  wr_ready_c;
  logic                  rd_hs;
  logic                  wr_hs;
  logic                  wr_starved_c;
  logic                  wr_force;
  dir_t                  pick_dir;

  assign wr_starved_c = (wr_wait_cnt_q == WAIT_MAX);
  assign wr_force     = bus.s_wr_valid && wr_starved_c;
  assign rd_hs        = (state_q == GRANT_RD) && bus.s_rd_valid && bus.m_ready;
  assign wr_hs        = (state_q == GRANT_WR) && bus.s_wr_valid && bus.m_ready;

  // Granted channel is wired straight through to the controller port.
  always_comb begin
    m_valid_c  = 1'b0;
    m_we_c     = 1'b0;
    m_addr_c   = '0;
    m_data_c   = '0;
    rd_ready_c = 1'b0;
    wr_ready_c = 1'b0;
    unique case (state_q)
      GRANT_RD: begin
        m_valid_c  = bus.s_rd_valid;
        m_addr_c   = bus.s_rd_addr;
        rd_ready_c = bus.m_ready;
      end
      GRANT_WR: begin
        m_valid_c  = bus.s_wr_valid;
        m_we_c     = 1'b1;
        m_addr_c   = bus.s_wr_addr;
        m_data_c   = bus.s_wr_data;
        wr_ready_c = bus.m_ready;
      end
      default: ;
    endcase
  end

  // Starved write beats everything; otherwise reads win ties.
  always_comb begin
    if (wr_force)             pick_dir = DIR_WR;
    else if (bus.s_rd_valid)  pick_dir = DIR_RD;
    else                      pick_dir = DIR_WR;
  end

  always_comb begin
    state_d       = state_q;
    last_dir_d    = last_dir_q;
    pending_dir_d = pending_dir_q;
    beat_cnt_d    = beat_cnt_q;
    turn_cnt_d    = turn_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.s_rd_valid || bus.s_wr_valid) begin
          if ((pick_dir != last_dir_q) && (TURNAROUND != 0)) begin
            state_d       = TURN;
            pending_dir_d = pick_dir;
            turn_cnt_d    = '0;
          end else begin
            state_d    = grant_state(pick_dir);
            last_dir_d = pick_dir;
            beat_cnt_d = '0;
          end
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d    = grant_state(pending_dir_q);
          last_dir_d = pending_dir_q;
          beat_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end
      GRANT_RD: begin
        if (rd_hs) beat_cnt_d = beat_cnt_q + 1'b1;
        // A starved write only preempts on a read handshake, so the accepted
        // beat always completes before the grant is dropped.
        if (!bus.s_rd_valid || (rd_hs && ((beat_cnt_q == BEAT_LAST) || wr_force)))
          state_d = IDLE;
      end
      GRANT_WR: begin
        if (wr_hs) beat_cnt_d = beat_cnt_q + 1'b1;
        if (!bus.s_wr_valid || (wr_hs && (beat_cnt_q == BEAT_LAST)))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait time only accrues while the write is pending and not granted: a
  // write stalled by the controller inside its own grant is not starving.
  always_comb begin
    wr_wait_cnt_d = wr_wait_cnt_q;
    if (!bus.s_wr_valid || wr_hs || (state_q == GRANT_WR))
      wr_wait_cnt_d = '0;
    else if (wr_wait_cnt_q != WAIT_MAX)
      wr_wait_cnt_d = wr_wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_dir_q    <= DIR_RD;
      pending_dir_q <= DIR_RD;
      beat_cnt_q    <= '0;
      turn_cnt_q    <= '0;
      wr_wait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      last_dir_q    <= last_dir_d;
      pending_dir_q <= pending_dir_d;
      beat_cnt_q    <= beat_cnt_d;
      turn_cnt_q    <= turn_cnt_d;
      wr_wait_cnt_q <= wr_wait_cnt_d;
    end
  end

  assign bus.m_valid         = m_valid_c;
  assign bus.m_we            = m_we_c;
  assign bus.m_addr          = m_addr_c;
  assign bus.m_data          = m_data_c;
  assign bus.s_rd_ready      = rd_ready_c;
  assign bus.s_wr_ready      = wr_ready_c;
  assign bus.wr_starved      = wr_starved_c;
  assign bus.s_rd_resp_valid = bus.m_rd_resp_valid;
  assign bus.s_rd_resp_data  = bus.m_rd_resp_data;

endmodule

// File: tb/tb_svc_sram_arbiter.sv
// Directed self-checking bench for svc_sram_arbiter at default parameters.
module tb_svc_sram_arbiter;
  import svc_sram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svc_sram_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bus ();

  svc_sram_arbiter #(
    .ADDR_WIDTH (20),
    .DATA_WIDTH (16),
    .BURST_MAX  (16),
    .WR_MAX_WAIT(8),
    .TURNAROUND (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_rd_valid      = 1'b0;
    bus.s_rd_addr       = '0;
    bus.s_wr_valid      = 1'b0;
    bus.s_wr_addr       = '0;
    bus.s_wr_data       = '0;
    bus.m_ready         = 1'b0;
    bus.m_rd_resp_valid = 1'b0;
    bus.m_rd_resp_data  = '0;
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with the DUT in IDLE.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned beats, runs, run_len, gap;
    int unsigned burst [3];
    int unsigned gaps  [3];
    int unsigned we_bad, addr_bad, data_bad, wrdy_bad, held_bad, nb;
    logic [15:0] seen [2];
    int lat, st_at, wr_at, last_rd;
    logic found, starved_after;

    rst = 1'b1;
    clear_inputs();

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_m_valid",    32'(bus.m_valid),    32'h0);
    chk("rst_rd_ready",   32'(bus.s_rd_ready), 32'h0);
    chk("rst_wr_ready",   32'(bus.s_wr_ready), 32'h0);
    chk("rst_wr_starved", 32'(bus.wr_starved), 32'h0);
    chk("rst_state",      32'(dut.state_q),    32'(IDLE));
    chk("rst_last_dir",   32'(dut.last_dir_q), 32'(DIR_RD));
    tick();

    // ---------------- reads only: 40 beats ----------------
    beats = 0; runs = 0; run_len = 0; gap = 0;
    we_bad = 0; addr_bad = 0; data_bad = 0; wrdy_bad = 0;
    for (int i = 0; i < 3; i++) begin burst[i] = 0; gaps[i] = 0; end
    for (int c = 0; c < 60; c++) begin
      bus.s_rd_valid = (beats < 40);
      bus.s_rd_addr  = 20'(beats);
      bus.m_ready    = 1'b1;
      #1;
      if (bus.s_wr_ready) wrdy_bad++;
      if (bus.m_valid && bus.m_ready) begin
        if (bus.m_we) we_bad++;
        if (bus.m_addr != 20'(beats)) addr_bad++;
        if (bus.m_data != 16'h0) data_bad++;
        if (run_len == 0 && runs < 3) gaps[runs] = gap;
        run_len++;
        beats++;
        gap = 0;
      end else begin
        if (run_len != 0) begin
          if (runs < 3) burst[runs] = run_len;
          runs++;
          run_len = 0;
        end
        gap++;
      end
      tick();
    end
    chk("rd_total_beats", beats, 32'd40);
    chk("rd_grants",      runs,  32'd3);
    chk("rd_burst0",      burst[0], 32'd16);
    chk("rd_burst1",      burst[1], 32'd16);
    chk("rd_burst2",      burst[2], 32'd8);
    chk("rd_gap0",        gaps[0], 32'd1);
    chk("rd_gap1",        gaps[1], 32'd1);
    chk("rd_gap2",        gaps[2], 32'd1);
    chk("rd_we_bad",      we_bad,   32'd0);
    chk("rd_addr_bad",    addr_bad, 32'd0);
    chk("rd_data_bad",    data_bad, 32'd0);
    chk("rd_wr_ready_bad", wrdy_bad, 32'd0);

    // ---------------- read response passthrough ----------------
    bus.m_rd_resp_valid = 1'b1;
    bus.m_rd_resp_data  = 16'h1234;
    #1;
    chk("resp_valid_hi", 32'(bus.s_rd_resp_valid), 32'h1);
    chk("resp_data_a",   32'(bus.s_rd_resp_data),  32'h1234);
    tick();
    bus.m_rd_resp_valid = 1'b0;
    bus.m_rd_resp_data  = 16'hBEEF;
    #1;
    chk("resp_valid_lo", 32'(bus.s_rd_resp_valid), 32'h0);
    chk("resp_data_b",   32'(bus.s_rd_resp_data),  32'hBEEF);
    tick();

    // ---------------- writes only after reset ----------------
    do_reset();
    bus.s_wr_valid = 1'b1;
    bus.s_wr_addr  = 20'h00010;
    bus.s_wr_data  = 16'hABCD;
    bus.m_ready    = 1'b1;
    found = 1'b0; lat = -1;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (bus.m_valid && bus.m_ready) begin
        found = 1'b1;
        lat   = c;
        chk("wr_m_we",     32'(bus.m_we),       32'h1);
        chk("wr_m_addr",   32'(bus.m_addr),     32'h00010);
        chk("wr_m_data",   32'(bus.m_data),     32'hABCD);
        chk("wr_s_ready",  32'(bus.s_wr_ready), 32'h1);
        chk("wr_rd_ready", 32'(bus.s_rd_ready), 32'h0);
      end
      tick();
    end
    bus.s_wr_valid = 1'b0;
    chk("wr_found",   32'(found), 32'h1);
    chk("wr_latency", 32'(lat),   32'd2);
    tick();
    tick();

    // ---------------- simultaneous rd+wr, then stalled write grant ----------------
    do_reset();
    bus.s_rd_valid = 1'b1;
    bus.s_rd_addr  = 20'h00033;
    bus.s_wr_valid = 1'b1;
    bus.s_wr_addr  = 20'h00022;
    bus.s_wr_data  = 16'h5A5A;
    bus.m_ready    = 1'b1;
    #1;
    chk("sim_idle_m_valid", 32'(bus.m_valid), 32'h0);
    tick();
    #1;
    chk("sim_m_valid",  32'(bus.m_valid),    32'h1);
    chk("sim_m_we",     32'(bus.m_we),       32'h0);
    chk("sim_m_addr",   32'(bus.m_addr),     32'h00033);
    chk("sim_rd_ready", 32'(bus.s_rd_ready), 32'h1);
    chk("sim_wr_ready", 32'(bus.s_wr_ready), 32'h0);
    tick();
    bus.s_rd_valid = 1'b0;
    bus.m_ready    = 1'b0;
    found = 1'b0; lat = -1;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (bus.m_valid && bus.m_we) begin
        found = 1'b1;
        lat   = c;
      end
      tick();
    end
    chk("stall_wr_found",   32'(found), 32'h1);
    chk("stall_wr_latency", 32'(lat),   32'd3);
    held_bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (!(bus.m_valid && bus.m_we && !bus.s_wr_ready)) held_bad++;
      if (bus.m_addr != 20'h00022 || bus.m_data != 16'h5A5A) held_bad++;
      tick();
    end
    chk("stall_held_bad",  held_bad, 32'd0);
    chk("stall_wait_cnt",  32'(dut.wr_wait_cnt_q), 32'd0);
    chk("stall_starved",   32'(bus.wr_starved),    32'h0);
    nb = 0;
    seen[0] = '0; seen[1] = '0;
    for (int c = 0; c < 4; c++) begin
      bus.m_ready    = 1'b1;
      bus.s_wr_valid = (c < 2);
      bus.s_wr_data  = (c == 0) ? 16'h1111 : 16'h2222;
      #1;
      if (bus.m_valid && bus.m_ready) begin
        if (nb < 2) seen[nb] = bus.m_data;
        nb++;
      end
      tick();
    end
    chk("stall_beats", nb, 32'd2);
    chk("stall_beat0", 32'(seen[0]), 32'h1111);
    chk("stall_beat1", 32'(seen[1]), 32'h2222);

    // ---------------- write starvation under continuous reads ----------------
    do_reset();
    bus.s_rd_valid = 1'b1;
    bus.m_ready    = 1'b1;
    bus.s_wr_addr  = 20'h00077;
    bus.s_wr_data  = 16'h7777;
    st_at = -1; wr_at = -1; last_rd = -1; starved_after = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) bus.s_wr_valid = 1'b1;
      if (wr_at >= 0) bus.s_wr_valid = 1'b0;
      #1;
      if (bus.wr_starved && st_at < 0) st_at = c;
      if (wr_at >= 0 && c == wr_at + 1) starved_after = bus.wr_starved;
      if (bus.m_valid && bus.m_ready && wr_at < 0) begin
        if (bus.m_we) wr_at = c;
        else          last_rd = c;
      end
      tick();
    end
    chk("starve_rise_delay", 32'(st_at - 5), 32'd8);
    chk("starve_last_read",  32'(last_rd),   32'd13);
    chk("starve_wr_accept",  32'(wr_at),     32'd16);
    chk("starve_within_15",  32'((wr_at >= 0) && (wr_at - 5 <= 15)), 32'h1);
    chk("starve_cleared",    32'(starved_after), 32'h0);
    bus.s_rd_valid = 1'b0;
    tick();
    tick();

    // ---------------- reset mid write burst ----------------
    do_reset();
    bus.s_wr_valid = 1'b1;
    bus.s_wr_addr  = 20'h00040;
    bus.s_wr_data  = 16'h4444;
    bus.m_ready    = 1'b1;
    tick();
    tick();
    tick();
    #1;
    chk("mid_pre_grant", 32'(bus.m_valid && bus.m_we), 32'h1);
    rst                 = 1'b1;
    bus.m_rd_resp_valid = 1'b1;
    bus.m_rd_resp_data  = 16'h9999;
    #1;
    chk("mid_resp_valid", 32'(bus.s_rd_resp_valid), 32'h1);
    chk("mid_resp_data",  32'(bus.s_rd_resp_data),  32'h9999);
    tick();
    rst                 = 1'b0;
    bus.m_rd_resp_valid = 1'b0;
    #1;
    chk("mid_m_valid",    32'(bus.m_valid),    32'h0);
    chk("mid_wr_ready",   32'(bus.s_wr_ready), 32'h0);
    chk("mid_rd_ready",   32'(bus.s_rd_ready), 32'h0);
    chk("mid_starved",    32'(bus.wr_starved), 32'h0);
    chk("mid_state",      32'(dut.state_q),    32'(IDLE));
    chk("mid_last_dir",   32'(dut.last_dir_q), 32'(DIR_RD));
    chk("mid_beat_cnt",   32'(dut.beat_cnt_q), 32'h0);
    chk("mid_turn_cnt",   32'(dut.turn_cnt_q), 32'h0);
    chk("mid_wait_cnt",   32'(dut.wr_wait_cnt_q), 32'h0);
    tick();
    #1;
    chk("mid_turn_gap",   32'(bus.m_valid), 32'h0);
    tick();
    #1;
    chk("mid_regrant_wr", 32'(bus.m_valid && bus.m_we), 32'h1);
    bus.s_wr_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
